alt_vip_common_control_packet_decoder: RTL

ALT_VIP_COMMON_CONTROL_PACKET_DECODER -- requirements
Module: alt_vip_common_control_packet_decoder

---
 rtl/alt_vip_common_control_packet_decoder_if.sv | 29 ++
 rtl/alt_vip_common_control_packet_decoder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/alt_vip_common_control_packet_decoder_if.sv
// Avalon-ST VIP stream bundle around the control packet decoder.
// din_*  : external VIP sink (header + payload beats, sop/eop framed).
// dout_* : video-only payload source towards the user algorithm.
// master : upstream/downstream environment side; slave : decoder side.
interface alt_vip_common_control_packet_decoder_if #(
    parameter int unsigned BITS_PER_SYMBOL  = 8,
    parameter int unsigned SYMBOLS_PER_BEAT = 3
);
    localparam int unsigned DATA_W = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;

    logic              din_ready;
    logic              din_valid;
    logic              din_sop;
    logic              din_eop;
    logic [DATA_W-1:0] din_data;
    logic              dout_ready;
    logic              dout_valid;
    logic [DATA_W-1:0] dout_data;

    modport master (
        output din_valid, din_sop, din_eop, din_data, dout_ready,
        input  din_ready, dout_valid, dout_data
    );

    modport slave (
        input  din_valid, din_sop, din_eop, din_data, dout_ready,
        output din_ready, dout_valid, dout_data
    );
endinterface

// File: rtl/alt_vip_common_control_packet_decoder.sv
// Splits an Avalon-ST VIP stream: video payload is forwarded with zero
// latency, control packets are decoded into width/height/interlaced, and
// any other packet type is swallowed.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   bus (slave)      : din_* sink and dout_* video source
//   start_of_video   : first forwarded beat of a video packet (combinational)
//   end_of_video     : last forwarded beat of a video packet (combinational)
//   width, height,
//   interlaced       : committed control-packet fields (registered)
//   vip_ctrl_valid   : one-cycle pulse when new fields are committed
//   ctrl_error       : one-cycle pulse on a truncated control packet
// Compile option: CTRL_PKT_LENGTH_CHECK_EN rejects control packets carrying
// fewer than nine symbols; when undefined every control eop commits and
// ctrl_error stays 0.
module alt_vip_common_control_packet_decoder #(
    parameter int unsigned BITS_PER_SYMBOL  = 8,
    parameter int unsigned SYMBOLS_PER_BEAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    alt_vip_common_control_packet_decoder_if.slave bus,
    output logic        start_of_video,
    output logic        end_of_video,
    output logic [15:0] width,
    output logic [15:0] height,
    output logic [3:0]  interlaced,
    output logic        vip_ctrl_valid,
    output logic        ctrl_error
);
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned NUM_FIELDS = 9;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {IDLE, CTRL, VIDEO, DISCARD} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             xfer;
    logic             hdr_ctrl;
    logic             hdr_video;
    logic             ctrl_beat;
    logic             ctrl_eop;
    logic             ctrl_full;
    logic             commit;
    logic             len_err;
    logic             sov_pend;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [31:0]      cnt_sum;
    logic [NIB_W-1:0] shadow     [NUM_FIELDS];
    logic [NIB_W-1:0] shadow_nxt [NUM_FIELDS];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and stream handshake; a sop beat is always a header, even mid-packet
    always_comb begin
        state_nxt      = state;
        bus.din_ready  = 1'b1;
        bus.dout_valid = 1'b0;
        bus.dout_data  = bus.din_data;
        if (state == VIDEO) begin
            bus.din_ready  = bus.dout_ready;
            bus.dout_valid = bus.din_valid & ~bus.din_sop;
        end
        start_of_video = bus.dout_valid & sov_pend;
        end_of_video   = bus.dout_valid & bus.din_eop;

        xfer      = bus.din_valid & bus.din_ready;
        hdr_ctrl  = xfer & bus.din_sop & (bus.din_data[NIB_W-1:0] == 4'hF);
        hdr_video = xfer & bus.din_sop & (bus.din_data[NIB_W-1:0] == 4'h0);
        if (xfer) begin
            if (bus.din_sop) begin
                if (hdr_video) begin
                    state_nxt = VIDEO;
                end else if (hdr_ctrl) begin
                    state_nxt = CTRL;
                end else begin
                    state_nxt = DISCARD;
                end
            end else if (bus.din_eop && (state != IDLE)) begin
                state_nxt = IDLE;
            end
        end
    end

    // Control payload: scatter symbol nibbles into the shadow fields by index
    always_comb begin
        ctrl_beat  = xfer & ~bus.din_sop & (state == CTRL);
        ctrl_eop   = ctrl_beat & bus.din_eop;
        cnt_sum    = 32'(cnt) + SYMBOLS_PER_BEAT;
        ctrl_full  = (cnt_sum >= NUM_FIELDS);
        cnt_nxt    = ctrl_full ? CNT_W'(NUM_FIELDS) : CNT_W'(cnt_sum);
        shadow_nxt = shadow;
        if (ctrl_beat) begin
            for (int i = 0; i < int'(SYMBOLS_PER_BEAT); i++) begin
                if (32'(cnt) + 32'(i) < NUM_FIELDS) begin
                    shadow_nxt[CNT_W'(32'(cnt) + 32'(i))] =
                        bus.din_data[i*BITS_PER_SYMBOL +: NIB_W];
                end
            end
        end
`ifdef CTRL_PKT_LENGTH_CHECK_EN
        commit  = ctrl_eop & ctrl_full;
        len_err = ctrl_eop & ~ctrl_full;
`else
        commit  = ctrl_eop;
        len_err = 1'b0;
`endif
    end

    // Shadow, committed fields and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            shadow         <= '{default: '0};
            width          <= '0;
            height         <= '0;
            interlaced     <= '0;
            vip_ctrl_valid <= 1'b0;
            ctrl_error     <= 1'b0;
            sov_pend       <= 1'b0;
        end else begin
            vip_ctrl_valid <= commit;
            ctrl_error     <= len_err;
            shadow         <= shadow_nxt;
            if (hdr_ctrl) begin
                cnt <= '0;
            end else if (ctrl_beat) begin
                cnt <= cnt_nxt;
            end
            // Commit includes the symbols of the eop beat itself
            if (commit) begin
                width      <= {shadow_nxt[0], shadow_nxt[1], shadow_nxt[2], shadow_nxt[3]};
                height     <= {shadow_nxt[4], shadow_nxt[5], shadow_nxt[6], shadow_nxt[7]};
                interlaced <= shadow_nxt[8];
            end
            if (hdr_video) begin
                sov_pend <= 1'b1;
            end else if (bus.dout_valid && bus.dout_ready) begin
                sov_pend <= 1'b0;
            end
        end
    end
endmodule
